// File: rtl/counter_pkg.sv
// Shared constants, FSM state encoding and divider helper for the display counter
// control front-end.
package counter_pkg;

    localparam int unsigned CLOCK_HZ = 32'd50_000_000;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    typedef enum logic [1:0] {
        CLEAR = ST_CLEAR,
        RUN   = ST_RUN,
        LOAD  = ST_LOAD,
        PAUSE = ST_PAUSE
    } state_e;

    // Number of system clocks per half period of the counter tick square wave.
    function automatic int unsigned half_period(input int unsigned clock_hz,
                                                input int unsigned freq_hz);
        return clock_hz / (32'd2 * freq_hz);
    endfunction

endpackage

// File: rtl/counter_ctrl_checker.sv
// Property checker for the counter_ctrl command outputs: commands never overlap and each
// one only appears in the state that owns it.
module counter_ctrl_checker
    import counter_pkg::*;
(
    input logic       clk,
    input logic       clear,
    input logic       load,
    input logic       step,
    input logic [1:0] state
);

    a_cmd_exclusive: assert property (@(posedge clk) $onehot0({clear, load, step}));
    a_clear_state:   assert property (@(posedge clk) clear |-> (state == ST_CLEAR));
    a_load_state:    assert property (@(posedge clk) load  |-> (state == ST_LOAD));
    a_step_state:    assert property (@(posedge clk) step  |-> (state == ST_RUN));

endmodule

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stability filter for one raw board switch; the filtered
// level only follows after DebounceCycles consecutive cycles of disagreement.
module input_debouncer #(
    parameter int unsigned DebounceCycles = 4,
    parameter logic        ResetValue     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned CNT_W = $clog2(DebounceCycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DebounceCycles - 1);

    logic             sync_meta_r;
    logic             sync_r;
    logic             filtered_r;
    logic [CNT_W-1:0] stable_cnt_r;

    // Synchronise the raw level, then accept it once it has disagreed long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_r  <= 1'b0;
            sync_r       <= 1'b0;
            filtered_r   <= ResetValue;
            stable_cnt_r <= {CNT_W{1'b0}};
        end else begin
            sync_meta_r <= raw;
            sync_r      <= sync_meta_r;
            if (sync_r == filtered_r) begin
                stable_cnt_r <= {CNT_W{1'b0}};
            end else if (stable_cnt_r == CNT_LAST) begin
                filtered_r   <= sync_r;
                stable_cnt_r <= {CNT_W{1'b0}};
            end else begin
                stable_cnt_r <= stable_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign filtered = filtered_r;

endmodule

// File: rtl/counter_ctrl.sv
// Control front-end of the 5-bit display counter: cleans the user switches, divides the
// system clock down to the counter tick and sequences clear/load/step commands.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned Frequency      = 32'd1_000_000,
    parameter int unsigned DebounceCycles = 32'd4
) (
    input  logic       i_clock_50mhz,
    input  logic       i_reset,
    input  logic       i_set,
    input  logic       i_pause,
    input  logic       i_count,
    input  logic       i_type,
    output logic       o_clear,
    output logic       o_load,
    output logic       o_step,
    output logic       o_up,
    output logic       o_type,
    output logic       o_sync_clock,
    output logic [1:0] o_state
);

    localparam int unsigned HALF  = half_period(CLOCK_HZ, Frequency);
    localparam int unsigned DIV_W = (HALF > 32'd1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 32'd1);

    if (HALF < 32'd1) begin : g_bad_frequency
        $error("counter_ctrl: Frequency is too high for CLOCK_HZ");
    end

    logic             set_f_s;
    logic             pause_f_s;
    logic             set_prev_r;
    logic             set_rise_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic             sync_clock_r;
    logic             tick_s;
    state_e           state_r;
    state_e           state_next_s;
    logic             clear_r;
    logic             load_r;
    logic             step_r;

    input_debouncer #(.DebounceCycles(DebounceCycles), .ResetValue(1'b0)) u_db_set (
        .clk(i_clock_50mhz), .reset(i_reset), .raw(i_set), .filtered(set_f_s)
    );
    input_debouncer #(.DebounceCycles(DebounceCycles), .ResetValue(1'b0)) u_db_pause (
        .clk(i_clock_50mhz), .reset(i_reset), .raw(i_pause), .filtered(pause_f_s)
    );
    input_debouncer #(.DebounceCycles(DebounceCycles), .ResetValue(1'b1)) u_db_count (
        .clk(i_clock_50mhz), .reset(i_reset), .raw(i_count), .filtered(o_up)
    );
    input_debouncer #(.DebounceCycles(DebounceCycles), .ResetValue(1'b0)) u_db_type (
        .clk(i_clock_50mhz), .reset(i_reset), .raw(i_type), .filtered(o_type)
    );

    // Free-running half-period divider; the tick square wave ignores pause and state
    always_ff @(posedge i_clock_50mhz) begin
        if (i_reset) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            sync_clock_r <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            sync_clock_r <= ~sync_clock_r;
        end else begin
            div_cnt_r    <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // A tick is the cycle whose wrap drives the square wave from low to high.
    assign tick_s     = (div_cnt_r == DIV_LAST) && !sync_clock_r;
    assign set_rise_s = set_f_s && !set_prev_r;

    // Next-state decode: set edge beats pause, pause beats tick
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CLEAR: begin
                state_next_s = RUN;
            end
            RUN: begin
                if (set_rise_s) begin
                    state_next_s = LOAD;
                end else if (pause_f_s) begin
                    state_next_s = PAUSE;
                end else begin
                    state_next_s = RUN;
                end
            end
            LOAD: begin
                if (pause_f_s) begin
                    state_next_s = PAUSE;
                end else begin
                    state_next_s = RUN;
                end
            end
            PAUSE: begin
                if (set_rise_s) begin
                    state_next_s = LOAD;
                end else if (!pause_f_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PAUSE;
                end
            end
            default: begin
                state_next_s = CLEAR;
            end
        endcase
    end

    // State and command registers; a step is only issued while staying in RUN
    always_ff @(posedge i_clock_50mhz) begin
        if (i_reset) begin
            state_r    <= CLEAR;
            clear_r    <= 1'b1;
            load_r     <= 1'b0;
            step_r     <= 1'b0;
            set_prev_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            clear_r    <= (state_next_s == CLEAR);
            load_r     <= (state_next_s == LOAD);
            step_r     <= (state_r == RUN) && (state_next_s == RUN) && tick_s;
            set_prev_r <= set_f_s;
        end
    end

    assign o_clear      = clear_r;
    assign o_load       = load_r;
    assign o_step       = step_r;
    assign o_sync_clock = sync_clock_r;
    assign o_state      = state_r;

endmodule
